max_track_stage: RTL

MAX_TRACK_STAGE -- requirements
Module: max_track_stage

---
 rtl/max_track_pkg.sv | 38 +++
 rtl/max_track_stage_skid.sv | 69 ++++++
 rtl/max_track_stage.sv | 104 ++++++++++
 3 files changed

// File: rtl/max_track_pkg.sv
// Shared types for the attention max-tracking stage: score/value formats,
// the packet carried between max tracking and exp-multiply, and helpers.
package max_track_pkg;

   localparam int MAX_EMBEDDING_DIM = 4;

   // Q4.3 signed score, Q9.8 signed value element
   typedef logic signed [7:0]  SCORE_QT;
   typedef logic signed [17:0] EXPMUL_VSHIFT_ELEM_T;
   typedef EXPMUL_VSHIFT_ELEM_T [MAX_EMBEDDING_DIM:0] EXPMUL_VSHIFT_QT;

   typedef struct packed {
      SCORE_QT         s;
      SCORE_QT         m_new;
      SCORE_QT         m_old;
      EXPMUL_VSHIFT_QT v;
      logic            first;
      logic            last;
      logic [15:0]     key_cnt;
   } MAX_TRACK_PKT_T;

   typedef enum logic {
      ROW_IDLE = 1'b0,
      ROW_OPEN = 1'b1
   } row_state_e;

   localparam SCORE_QT SCORE_MIN = SCORE_QT'(8'h80);

   function automatic logic [15:0] key_cnt_inc(input logic [15:0] k);
      return (k == 16'hFFFF) ? k : k + 16'd1;
   endfunction

   // Ties keep the running max so m_new never moves on an equal score.
   function automatic SCORE_QT score_max(input SCORE_QT s, input SCORE_QT m_run);
      return (s > m_run) ? s : m_run;
   endfunction

endpackage

// File: rtl/max_track_stage_skid.sv
// Two-entry skid buffer: registered upstream ready, output register plus one
// overflow entry so the ready path never sees downstream ready combinationally.
module skid_buffer
   import max_track_pkg::*;
#(
   parameter type T = MAX_TRACK_PKT_T
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in_vld_i,
   output logic in_rdy_o,
   input  T     in_data_i,
   output logic out_vld_o,
   input  logic out_rdy_i,
   output T     out_data_o
);

   logic out_vld_q, out_vld_d;
   logic skid_vld_q, skid_vld_d;
   logic rdy_q, rdy_d;
   T     out_data_q, out_data_d;
   T     skid_data_q, skid_data_d;
   logic in_fire;

   assign in_fire = in_vld_i && rdy_q;

   // rdy_q tracks an empty skid entry, so an accepted beat never meets a full skid.
   always_comb begin
      out_vld_d   = out_vld_q;
      out_data_d  = out_data_q;
      skid_vld_d  = skid_vld_q;
      skid_data_d = skid_data_q;
      if (!out_vld_q || out_rdy_i) begin
         if (skid_vld_q) begin
            out_vld_d  = 1'b1;
            out_data_d = skid_data_q;
            skid_vld_d = 1'b0;
         end else begin
            out_vld_d = in_fire;
            if (in_fire) out_data_d = in_data_i;
         end
      end else if (in_fire) begin
         skid_vld_d  = 1'b1;
         skid_data_d = in_data_i;
      end
      rdy_d = !skid_vld_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_vld_q   <= 1'b0;
         skid_vld_q  <= 1'b0;
         rdy_q       <= 1'b0;
         out_data_q  <= '0;
         skid_data_q <= '0;
      end else begin
         out_vld_q   <= out_vld_d;
         skid_vld_q  <= skid_vld_d;
         rdy_q       <= rdy_d;
         out_data_q  <= out_data_d;
         skid_data_q <= skid_data_d;
      end
   end

   assign in_rdy_o   = rdy_q;
   assign out_vld_o  = out_vld_q;
   assign out_data_o = out_data_q;

endmodule

// File: rtl/max_track_stage.sv
// Running-max tracker over the keys of a query row; tags each beat with the
// previous and updated max for the downstream exp(m_old - m_new) rescale.
module max_track_stage
   import max_track_pkg::*;
#(
   parameter int VDIM = MAX_EMBEDDING_DIM + 1
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               vld_in,
   output logic                               rdy_out,
   input  SCORE_QT                            s_in,
   input  EXPMUL_VSHIFT_ELEM_T [VDIM-1:0]     v_in,
   input  logic                               first_in,
   input  logic                               last_in,
   output logic                               vld_out,
   input  logic                               rdy_in,
   output SCORE_QT                            s_out,
   output SCORE_QT                            m_new_out,
   output SCORE_QT                            m_old_out,
   output EXPMUL_VSHIFT_ELEM_T [VDIM-1:0]     v_out,
   output logic                               first_out,
   output logic                               last_out,
   output logic [15:0]                        key_cnt_out,
   output logic                               err
);

   row_state_e     state_q, state_d;
   SCORE_QT        m_run_q, m_run_d;
   logic [15:0]    key_q, key_d;
   logic           err_q, err_d;
   logic           in_fire, opening, proto_err;
   MAX_TRACK_PKT_T in_pkt, out_pkt;

   assign in_fire = vld_in && rdy_out;

   // A first_in mid-row abandons the open row; a beat in IDLE opens one regardless.
   always_comb begin
      opening   = first_in || (state_q == ROW_IDLE);
      proto_err = (state_q == ROW_IDLE) ? !first_in : first_in;

      in_pkt.s     = s_in;
      in_pkt.v     = v_in;
      in_pkt.first = first_in;
      in_pkt.last  = last_in;
      if (opening) begin
         in_pkt.m_new   = s_in;
         in_pkt.m_old   = s_in;
         in_pkt.key_cnt = 16'd1;
      end else begin
         in_pkt.m_new   = score_max(s_in, m_run_q);
         in_pkt.m_old   = m_run_q;
         in_pkt.key_cnt = key_cnt_inc(key_q);
      end

      state_d = state_q;
      m_run_d = m_run_q;
      key_d   = key_q;
      err_d   = err_q;
      if (in_fire) begin
         state_d = last_in ? ROW_IDLE : ROW_OPEN;
         m_run_d = in_pkt.m_new;
         key_d   = in_pkt.key_cnt;
         err_d   = err_q | proto_err;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ROW_IDLE;
         m_run_q <= SCORE_MIN;
         key_q   <= 16'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         m_run_q <= m_run_d;
         key_q   <= key_d;
         err_q   <= err_d;
      end
   end

   skid_buffer #(
      .T(MAX_TRACK_PKT_T)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_vld_i  (vld_in),
      .in_rdy_o  (rdy_out),
      .in_data_i (in_pkt),
      .out_vld_o (vld_out),
      .out_rdy_i (rdy_in),
      .out_data_o(out_pkt)
   );

   assign s_out       = out_pkt.s;
   assign m_new_out   = out_pkt.m_new;
   assign m_old_out   = out_pkt.m_old;
   assign v_out       = out_pkt.v;
   assign first_out   = out_pkt.first;
   assign last_out    = out_pkt.last;
   assign key_cnt_out = out_pkt.key_cnt;
   assign err         = err_q;

endmodule
